fetch: RTL and testbench

FETCH -- requirements
Module: fetch

---
 rtl/fetch.sv | 202 ++++++++++++++++++++
 tb/tb_fetch.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch.sv
// Instruction fetch unit: reads 32-bit or 64-bit instructions over a
// classic cyc/stb/ack bus and presents them to the decode stage.
// A first word with bit 0 set means a second word follows.
// Optional build macro: BEXKAT1_FETCH_TIMEOUT_EN adds a bus watchdog that
// abandons an access after TIMEOUT cycles without ack. When it fires, the
// unit raises fault_o and halts.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          TIMEOUT  = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pc_set_i,
  input  logic [31:0] pc_i,
  input  logic        stall_i,
  input  logic        halt_i,
  output logic        bus_cyc_o,
  output logic        bus_stb_o,
  output logic [31:0] bus_adr_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_dat_i,
  output logic [63:0] ir_o,
  output logic [31:0] pc_o,
  output logic        valid_o,
  output logic        halt_o,
  output logic        fault_o
);

  typedef enum logic [2:0] {
    S_FETCH1,
    S_FETCH2,
    S_HOLD,
    S_DRAIN,
    S_HALT
  } state_t;

  // The watchdog counter is 8 bits wide, so TIMEOUT must fit in 1..255.
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
    $error("fetch: TIMEOUT must be in 1..255");
  end

  state_t      state_q, state_d;
  logic [31:0] adr_q;
  logic [31:0] drain_adr_q;
  logic [63:0] ir_q;
  logic [31:0] pc_q;
  logic        halt_pend_q;

  logic        access;
  logic        halt_req;
  logic        issue;
  logic [31:0] issue_adr;
  logic [31:0] adr_inc;
  logic [31:0] pc_set_adr;
  logic        tmo_hit;

  assign access     = (state_q == S_FETCH1) || (state_q == S_FETCH2) || (state_q == S_DRAIN);
  assign halt_req   = halt_i | halt_pend_q;
  assign adr_inc    = adr_q + 32'd4;
  assign pc_set_adr = {pc_i[31:2], 2'b00};

`ifdef BEXKAT1_FETCH_TIMEOUT_EN
  logic [7:0] tmo_cnt_q;
  logic       fault_q;

  assign tmo_hit = access && !bus_ack_i && (tmo_cnt_q == 8'(TIMEOUT - 1));

  // Count cycles spent waiting on one access. A redirect into DRAIN keeps
  // counting because the access is still the same one.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_cnt_q <= 8'd0;
      fault_q   <= 1'b0;
    end else begin
      if (!access || bus_ack_i)
        tmo_cnt_q <= 8'd0;
      else
        tmo_cnt_q <= tmo_cnt_q + 8'd1;
      if (tmo_hit)
        fault_q <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i)
      state_q <= S_FETCH1;
    else
      state_q <= state_d;
  end

  // Next state. Also computes whether a new access starts next cycle, and
  // at which address.
  always_comb begin
    state_d   = state_q;
    issue     = 1'b0;
    issue_adr = adr_q;
    case (state_q)
      S_FETCH1, S_FETCH2: begin
        if (tmo_hit) begin
          state_d = S_HALT;
        end else if (bus_ack_i) begin
          if (halt_req) begin
            state_d = S_HALT;
          end else if (pc_set_i) begin
            state_d   = S_FETCH1;
            issue     = 1'b1;
            issue_adr = pc_set_adr;
          end else if (state_q == S_FETCH1 && bus_dat_i[0]) begin
            state_d   = S_FETCH2;
            issue     = 1'b1;
            issue_adr = adr_inc;
          end else begin
            state_d = S_HOLD;
          end
        end else if (pc_set_i) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (tmo_hit) begin
          state_d = S_HALT;
        end else if (bus_ack_i) begin
          if (halt_req) begin
            state_d = S_HALT;
          end else begin
            state_d   = S_FETCH1;
            issue     = 1'b1;
            issue_adr = pc_set_i ? pc_set_adr : drain_adr_q;
          end
        end
      end
      S_HOLD: begin
        if (halt_i) begin
          state_d = S_HALT;
        end else if (pc_set_i) begin
          state_d   = S_FETCH1;
          issue     = 1'b1;
          issue_adr = pc_set_adr;
        end else if (!stall_i) begin
          state_d   = S_FETCH1;
          issue     = 1'b1;
          issue_adr = pc_q;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  // Latch a halt request seen mid-access so it takes effect once the ack arrives.
  always_ff @(posedge clk_i) begin
    if (rst_i)
      halt_pend_q <= 1'b0;
    else if (halt_i)
      halt_pend_q <= 1'b1;
  end

  // Bus address, redirect target and instruction/pc capture.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      adr_q <= RESET_PC;
      ir_q  <= 64'h0;
      pc_q  <= RESET_PC;
    end else begin
      if (issue)
        adr_q <= issue_adr;
      if (access && pc_set_i && !bus_ack_i)
        drain_adr_q <= pc_set_adr;
      if (state_q == S_FETCH1 && (state_d == S_HOLD || state_d == S_FETCH2))
        ir_q[31:0] <= bus_dat_i;
      if (state_q == S_FETCH1 && state_d == S_HOLD) begin
        ir_q[63:32] <= 32'h0;
        pc_q        <= adr_inc;
      end
      if (state_q == S_FETCH2 && state_d == S_HOLD) begin
        ir_q[63:32] <= bus_dat_i;
        pc_q        <= adr_inc;
      end
    end
  end

  // Outputs. The bus is gated by rst_i so nothing is requested while reset is held.
  always_comb begin
    bus_cyc_o = access & ~rst_i;
    bus_stb_o = access & ~rst_i;
    bus_adr_o = adr_q;
    ir_o      = ir_q;
    pc_o      = pc_q;
    valid_o   = (state_q == S_HOLD);
    halt_o    = (state_q == S_HALT);
`ifdef BEXKAT1_FETCH_TIMEOUT_EN
    fault_o   = fault_q;
`else
    fault_o   = 1'b0;
`endif
  end

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: table of single fetches after a redirect,
// plus sequences for reset, stall, drain, halt and bus timeout.
module tb_fetch;

`ifdef BEXKAT1_FETCH_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst_i, pc_set_i, stall_i, halt_i;
  logic [31:0] pc_i;
  logic        bus_cyc_o, bus_stb_o, bus_ack_i;
  logic [31:0] bus_adr_o, bus_dat_i;
  logic [63:0] ir_o;
  logic [31:0] pc_o;
  logic        valid_o, halt_o, fault_o;

  always #5 clk = ~clk;

  fetch #(.RESET_PC(32'h0), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst_i), .pc_set_i(pc_set_i), .pc_i(pc_i),
    .stall_i(stall_i), .halt_i(halt_i),
    .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_adr_o(bus_adr_o),
    .bus_ack_i(bus_ack_i), .bus_dat_i(bus_dat_i),
    .ir_o(ir_o), .pc_o(pc_o), .valid_o(valid_o), .halt_o(halt_o), .fault_o(fault_o)
  );

  // Bus slave: ack once the request has waited ack_dly cycles.
  logic [31:0] mem [0:255];
  int ack_dly = 1;
  bit ack_en = 1'b1;
  int wait_cnt = 0;
  int n_acks = 0;

  always @(negedge clk) begin
    if (bus_cyc_o && bus_stb_o && ack_en && wait_cnt >= ack_dly) begin
      bus_ack_i = 1'b1;
      bus_dat_i = mem[bus_adr_o[9:2]];
    end else begin
      bus_ack_i = 1'b0;
      bus_dat_i = 32'hDEAD_DEAD;
    end
  end

  always @(posedge clk) begin
    if (bus_ack_i && bus_cyc_o) n_acks <= n_acks + 1;
    if (bus_cyc_o && !bus_ack_i) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input int max, output int lat);
    lat = 0;
    while (!valid_o && lat < max) begin
      tick();
      lat++;
    end
  endtask

  typedef struct {
    logic [31:0] start;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [63:0] ir;
    logic [31:0] pc;
    int          acks;
    int          lat;
  } vec_t;

  vec_t vt [7];

  // Redirect during an outstanding access (optionally twice), check that the
  // old data is dropped and the fetch restarts at the final target.
  task automatic drain_seq(input logic [31:0] t1, input bit second, input logic [31:0] t2);
    logic [31:0] tgt, old_adr, word;
    int spurious, adr_bad, lat;
    bit seen;
    tgt  = second ? t2 : t1;
    word = 32'h600D_0000 ^ tgt;
    mem[tgt[9:2]] = word;
    ack_dly = 3;
    stall_i = 1'b0;
    tick();
    stall_i = 1'b1;
    old_adr = bus_adr_o;
    pc_set_i = 1'b1;
    pc_i = t1;
    tick();
    if (second) begin
      pc_i = t2;
      tick();
    end
    pc_set_i = 1'b0;
    spurious = 0;
    adr_bad = 0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (valid_o) spurious++;
      if (bus_cyc_o && bus_adr_o == tgt) seen = 1'b1;
      else begin
        if (bus_cyc_o && bus_adr_o != old_adr) adr_bad++;
        tick();
      end
    end
    check("drain_restart_adr", 64'(seen), 64'd1);
    check("drain_no_spurious_valid", 64'(spurious), 64'd0);
    check("drain_adr_stable", 64'(adr_bad), 64'd0);
    ack_dly = 1;
    wait_valid(20, lat);
    check("drain_ir", ir_o, {32'h0, word});
    check("drain_pc", 64'(pc_o), 64'(tgt + 32'd4));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, a0, c;
    logic [31:0] a;
    logic [63:0] s_ir;
    logic [31:0] s_pc;

    vt[0] = '{32'h0000_0000, 32'h7000_0000, 32'h0000_0000, 64'h0000_0000_7000_0000, 32'h0000_0004, 1, 2};
    vt[1] = '{32'h0000_0008, 32'h2000_0001, 32'h1234_5678, 64'h1234_5678_2000_0001, 32'h0000_0010, 2, 4};
    vt[2] = '{32'h0000_0100, 32'hDEAD_BEE0, 32'h0000_0000, 64'h0000_0000_DEAD_BEE0, 32'h0000_0104, 1, 2};
    vt[3] = '{32'h0000_0042, 32'hA5A5_0003, 32'hFFFF_FFFF, 64'hFFFF_FFFF_A5A5_0003, 32'h0000_0048, 2, 4};
    vt[4] = '{32'hFFFF_FFFC, 32'h0000_0011, 32'h5555_AAAA, 64'h5555_AAAA_0000_0011, 32'h0000_0004, 2, 4};
    vt[5] = '{32'hFFFF_FFF8, 32'h0BAD_F00C, 32'h0000_0000, 64'h0000_0000_0BAD_F00C, 32'hFFFF_FFFC, 1, 2};
    vt[6] = '{32'hFFFF_FFFC, 32'h0000_0010, 32'h0000_0002, 64'h0000_0000_0000_0010, 32'h0000_0000, 1, 2};

    for (int i = 0; i < 256; i++) mem[i] = 32'(i) << 4;
    mem[0] = 32'h7000_0000;

    rst_i = 1'b1; pc_set_i = 1'b0; pc_i = 32'h0; stall_i = 1'b1; halt_i = 1'b0;
    bus_ack_i = 1'b0; bus_dat_i = 32'h0;

    // Reset state and first fetch from RESET_PC
    tick();
    tick();
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_ir", ir_o, 64'h0);
    check("rst_pc", 64'(pc_o), 64'h0);
    check("rst_halt", 64'(halt_o), 64'd0);
    check("rst_fault", 64'(fault_o), 64'd0);
    check("rst_cyc", 64'({bus_cyc_o, bus_stb_o}), 64'd0);
    rst_i = 1'b0;
    #1;
    check("boot_cyc_adr", {31'h0, bus_cyc_o, bus_adr_o}, {31'h0, 1'b1, 32'h0});
    wait_valid(20, lat);
    check("boot_latency", 64'(lat), 64'd2);
    check("boot_ir", ir_o, 64'h0000_0000_7000_0000);
    check("boot_pc", 64'(pc_o), 64'h4);

    // Table: redirect from HOLD and fetch one instruction
    for (int i = 0; i < 7; i++) begin
      a = {vt[i].start[31:2], 2'b00};
      mem[a[9:2]] = vt[i].w0;
      a = a + 32'd4;
      mem[a[9:2]] = vt[i].w1;
      a0 = n_acks;
      pc_set_i = 1'b1;
      pc_i = vt[i].start;
      tick();
      pc_set_i = 1'b0;
      wait_valid(20, lat);
      check($sformatf("vec%0d_ir", i), ir_o, vt[i].ir);
      check($sformatf("vec%0d_pc", i), 64'(pc_o), 64'(vt[i].pc));
      check($sformatf("vec%0d_accesses", i), 64'(n_acks - a0), 64'(vt[i].acks));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vt[i].lat));
    end

    // Stall holds outputs and keeps the bus idle
    s_ir = ir_o;
    s_pc = pc_o;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("stall%0d_ir", k), ir_o, s_ir);
      check($sformatf("stall%0d_pc_valid_cyc", k), {30'h0, pc_o, valid_o, bus_cyc_o}, {30'h0, s_pc, 1'b1, 1'b0});
    end
    stall_i = 1'b0;
    tick();
    stall_i = 1'b1;
    check("consume_valid_cleared", 64'(valid_o), 64'd0);
    check("consume_next_fetch", {31'h0, bus_cyc_o, bus_adr_o}, {31'h0, 1'b1, s_pc});
    wait_valid(20, lat);
    check("consume_refetch_valid", 64'(valid_o), 64'd1);

    // Redirect while an access waits for ack
    drain_seq(32'h0000_0100, 1'b0, 32'h0);
    drain_seq(32'h0000_0300, 1'b1, 32'h0000_0200);

    // Halt during an outstanding access
    ack_dly = 2;
    a0 = n_acks;
    stall_i = 1'b0;
    tick();
    stall_i = 1'b1;
    halt_i = 1'b1;
    tick();
    halt_i = 1'b0;
    c = 0;
    while (!halt_o && c < 10) begin
      if (valid_o) c = 100;
      tick();
      c++;
    end
    check("halt_reached", 64'(halt_o), 64'd1);
    check("halt_access_completed", 64'(n_acks - a0), 64'd1);
    check("halt_bus_idle_valid", 64'({bus_cyc_o, valid_o}), 64'd0);
    pc_set_i = 1'b1;
    pc_i = 32'h100;
    tick();
    pc_set_i = 1'b0;
    repeat (4) tick();
    check("halt_ignores_pc_set", 64'({halt_o, bus_cyc_o, valid_o}), 64'b100);
    rst_i = 1'b1;
    tick();
    check("halt_cleared_by_rst", 64'({halt_o, valid_o}), 64'd0);
    rst_i = 1'b0;
    ack_dly = 1;

    // Bus that never acks
    ack_en = 1'b0;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
`ifdef BEXKAT1_FETCH_TIMEOUT_EN
    c = 0;
    for (int k = 0; k < 20 && bus_cyc_o; k++) begin
      c++;
      tick();
    end
    check("tmo_cycles", 64'(c), 64'(TMO));
    check("tmo_fault_halt", 64'({fault_o, halt_o, bus_cyc_o}), 64'b110);
    rst_i = 1'b1;
    tick();
    check("tmo_cleared_by_rst", 64'({fault_o, halt_o}), 64'd0);
    rst_i = 1'b0;
    ack_en = 1'b1;
`else
    repeat (30) tick();
    check("noack_still_waiting", {31'h0, bus_cyc_o, bus_adr_o}, {31'h0, 1'b1, 32'h0});
    check("noack_no_fault", 64'({fault_o, halt_o, valid_o}), 64'd0);
    ack_en = 1'b1;
    wait_valid(20, lat);
    check("noack_late_ack_valid", 64'(valid_o), 64'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
